// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, entry layout and reserved tags for the reorder buffer.
// No ports; imported by reorder_buffer and rb_wb_select.
package reorder_buffer_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int RB_SIZE    = 8;
  localparam int RB_INDEX   = 3;
  localparam int RB_COUNT_W = RB_INDEX + 1;
  localparam int FU_NUM     = 4;
  localparam int REG_INDEX  = 5;

  // Tag an FU drives when it has no destination entry.
  // That entry slot can therefore never accept a writeback.
  localparam logic [RB_INDEX-1:0] NULL = '1;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic                 is_branch;
    logic [REG_INDEX-1:0] rd;
    logic [WORD_SIZE-1:0] value;
  } rb_entry_t;

  localparam rb_entry_t RB_ENTRY_CLEAR = '0;

endpackage

// File: rtl/rb_wb_select.sv
// Per-entry writeback match: finds the lowest FU slot targeting IDX.
// Ports: valid_i/index_i/data_i (FU buses), hit_o, data_o (winner).
module rb_wb_select
  import reorder_buffer_pkg::*;
#(
  parameter logic [RB_INDEX-1:0] IDX = '0
) (
  input  logic [FU_NUM-1:0]           valid_i,
  input  logic [FU_NUM*RB_INDEX-1:0]  index_i,
  input  logic [FU_NUM*WORD_SIZE-1:0] data_i,
  output logic                        hit_o,
  output logic [WORD_SIZE-1:0]        data_o
);

  // Scan from the top slot down so the lowest slot overwrites last.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int f = FU_NUM - 1; f >= 0; f--) begin
      if (valid_i[f] &&
          index_i[f*RB_INDEX +: RB_INDEX] == IDX &&
          IDX != NULL) begin
        hit_o  = 1'b1;
        data_o = data_i[f*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocate, capture FU results, rebroadcast,
// retire in order, flush on taken branch. Ports: alloc_*, FU buses, CDB_*, commit_*.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alloc_req,
  input  logic [REG_INDEX-1:0]        alloc_reg,
  input  logic                        alloc_is_branch,
  output logic                        alloc_ack,
  output logic [RB_INDEX-1:0]         alloc_index,
  output logic                        full,
  input  logic [FU_NUM*WORD_SIZE-1:0] data_bus,
  input  logic [FU_NUM-1:0]           valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]  RB_index_bus,
  output logic [FU_NUM-1:0]           reset_bus,
  output logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data,
  output logic [RB_SIZE-1:0]          CDB_data_valid,
  output logic                        commit_valid,
  output logic                        commit_we,
  output logic [REG_INDEX-1:0]        commit_reg,
  output logic [WORD_SIZE-1:0]        commit_data,
  output logic [RB_INDEX-1:0]         commit_index,
  output logic                        flush
);

  rb_entry_t             ent_q [RB_SIZE];
  rb_entry_t             ent_d [RB_SIZE];
  logic [RB_INDEX-1:0]   head_q, head_d;
  logic [RB_INDEX-1:0]   tail_q, tail_d;
  logic [RB_COUNT_W-1:0] count_q, count_d;

  logic                 cv_q, cwe_q, flush_q;
  logic [REG_INDEX-1:0] creg_q;
  logic [WORD_SIZE-1:0] cdata_q;
  logic [RB_INDEX-1:0]  cidx_q;
  logic [FU_NUM-1:0]    rbus_q;

  logic                 wb_hit  [RB_SIZE];
  logic [WORD_SIZE-1:0] wb_data [RB_SIZE];

  rb_entry_t hd;
  logic      retire;
  logic      flush_now;

  assign hd        = ent_q[head_q];
  assign retire    = hd.busy & hd.done;
  assign flush_now = retire & hd.is_branch & hd.value[0];

  assign full        = (count_q == RB_COUNT_W'(RB_SIZE));
  assign alloc_ack   = alloc_req & ~full & ~flush_now & ~reset;
  assign alloc_index = tail_q;

  for (genvar i = 0; i < RB_SIZE; i++) begin : g_ent
    rb_wb_select #(
      .IDX(RB_INDEX'(i))
    ) u_sel (
      .valid_i(valid_bus),
      .index_i(RB_index_bus),
      .data_i (data_bus),
      .hit_o  (wb_hit[i]),
      .data_o (wb_data[i])
    );
    assign CDB_data_data[i*WORD_SIZE +: WORD_SIZE] = ent_q[i].value;
    assign CDB_data_valid[i] = ent_q[i].busy & ent_q[i].done;
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_now) begin
      for (int i = 0; i < RB_SIZE; i++) begin
        ent_d[i] = RB_ENTRY_CLEAR;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (retire) begin
        ent_d[head_q] = RB_ENTRY_CLEAR;
        head_d        = head_q + RB_INDEX'(1);
      end
      // A free tail slot is never the retiring head nor a wb target.
      if (alloc_ack) begin
        ent_d[tail_q].busy      = 1'b1;
        ent_d[tail_q].done      = 1'b0;
        ent_d[tail_q].is_branch = alloc_is_branch;
        ent_d[tail_q].rd        = alloc_reg;
        ent_d[tail_q].value     = '0;
        tail_d                  = tail_q + RB_INDEX'(1);
      end
      for (int i = 0; i < RB_SIZE; i++) begin
        if (wb_hit[i] && ent_q[i].busy && !ent_q[i].done) begin
          ent_d[i].done  = 1'b1;
          ent_d[i].value = wb_data[i];
        end
      end
      count_d = count_q
              + RB_COUNT_W'(alloc_ack)
              - RB_COUNT_W'(retire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RB_SIZE; i++) begin
        ent_q[i] <= RB_ENTRY_CLEAR;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cv_q    <= 1'b0;
      cwe_q   <= 1'b0;
      creg_q  <= '0;
      cdata_q <= '0;
      cidx_q  <= '0;
      flush_q <= 1'b0;
      rbus_q  <= '1;
    end else begin
      for (int i = 0; i < RB_SIZE; i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cv_q    <= retire;
      cwe_q   <= retire & ~hd.is_branch;
      creg_q  <= retire ? hd.rd : '0;
      cdata_q <= retire ? hd.value : '0;
      cidx_q  <= retire ? head_q : '0;
      flush_q <= flush_now;
      rbus_q  <= flush_now ? '1 : valid_bus;
    end
  end

  // Release every FU for as long as reset is held.
  assign reset_bus    = rbus_q | {FU_NUM{reset}};
  assign commit_valid = cv_q;
  assign commit_we    = cwe_q;
  assign commit_reg   = creg_q;
  assign commit_data  = cdata_q;
  assign commit_index = cidx_q;
  assign flush        = flush_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized
// traffic against a program-order queue model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk;
  logic reset;
  logic alloc_req;
  logic [REG_INDEX-1:0] alloc_reg;
  logic alloc_is_branch;
  logic alloc_ack;
  logic [RB_INDEX-1:0] alloc_index;
  logic full;
  logic [FU_NUM*WORD_SIZE-1:0] data_bus;
  logic [FU_NUM-1:0] valid_bus;
  logic [FU_NUM*RB_INDEX-1:0] RB_index_bus;
  logic [FU_NUM-1:0] reset_bus;
  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data;
  logic [RB_SIZE-1:0] CDB_data_valid;
  logic commit_valid;
  logic commit_we;
  logic [REG_INDEX-1:0] commit_reg;
  logic [WORD_SIZE-1:0] commit_data;
  logic [RB_INDEX-1:0] commit_index;
  logic flush;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [2:0]  idx;
    logic [4:0]  rd;
    logic        br;
    logic        done;
    logic [15:0] val;
  } mrec_t;

  reorder_buffer dut (
    .clk(clk),
    .reset(reset),
    .alloc_req(alloc_req),
    .alloc_reg(alloc_reg),
    .alloc_is_branch(alloc_is_branch),
    .alloc_ack(alloc_ack),
    .alloc_index(alloc_index),
    .full(full),
    .data_bus(data_bus),
    .valid_bus(valid_bus),
    .RB_index_bus(RB_index_bus),
    .reset_bus(reset_bus),
    .CDB_data_data(CDB_data_data),
    .CDB_data_valid(CDB_data_valid),
    .commit_valid(commit_valid),
    .commit_we(commit_we),
    .commit_reg(commit_reg),
    .commit_data(commit_data),
    .commit_index(commit_index),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    alloc_req = 1'b0;
    alloc_reg = '0;
    alloc_is_branch = 1'b0;
    data_bus = '0;
    valid_bus = '0;
    RB_index_bus = '0;
  endtask

  task automatic fu(input int f, input logic [2:0] ix,
                    input logic [15:0] d);
    valid_bus[f] = 1'b1;
    RB_index_bus[f*3 +: 3] = ix;
    data_bus[f*16 +: 16] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_in();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic br);
    alloc_req = 1'b1;
    alloc_reg = rd;
    alloc_is_branch = br;
    tick();
    alloc_req = 1'b0;
    alloc_is_branch = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr_in();
    tick();
    tick();
    n_chk++;
    if ({commit_valid, commit_we, flush, full} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 0000",
               {commit_valid, commit_we, flush, full});
    end
    n_chk++;
    if ({CDB_data_valid, CDB_data_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_cdb got %h/%h want 0",
               CDB_data_valid, CDB_data_data);
    end
    n_chk++;
    if (reset_bus !== 4'hF || alloc_index !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_bus got %b/%0d want 1111/0",
               reset_bus, alloc_index);
    end
    reset = 1'b0;
  endtask

  task automatic test_writeback();
    logic ok;
    do_reset();
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      alloc_req = 1'b1;
      alloc_reg = 5'(k + 1);
      #1;
      if (alloc_ack !== 1'b1 || alloc_index !== 3'(k)) ok = 1'b0;
      tick();
    end
    alloc_req = 1'b0;
    n_chk++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_alloc got ack/index wrong want 1/0..2");
    end
    fu(2, 3'd1, 16'h0055);
    tick();
    clr_in();
    n_chk++;
    if (CDB_data_valid !== 8'h02 || CDB_data_data[31:16] !== 16'h0055) begin
      n_fail++;
      $display("FAIL wb_cdb got %b/%h want 00000010/0055",
               CDB_data_valid, CDB_data_data[31:16]);
    end
    n_chk++;
    if (reset_bus !== 4'b0100 || commit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_rbus got %b/%b want 0100/0",
               reset_bus, commit_valid);
    end
    tick();
    n_chk++;
    if (reset_bus !== 4'b0000 || commit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_rbus_end got %b/%b want 0000/0",
               reset_bus, commit_valid);
    end
  endtask

  task automatic test_in_order();
    logic [15:0] vals [3];
    vals[0] = 16'h0100;
    vals[1] = 16'h0111;
    vals[2] = 16'h0222;
    do_reset();
    for (int k = 0; k < 3; k++) alloc(5'(k + 1), 1'b0);
    fu(0, 3'd2, vals[2]);
    tick();
    clr_in();
    fu(0, 3'd0, vals[0]);
    tick();
    clr_in();
    n_chk++;
    if (commit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL order_early got %b want 0", commit_valid);
    end
    fu(1, 3'd1, vals[1]);
    tick();
    clr_in();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({commit_valid, commit_we, flush} !== 3'b110 ||
          commit_index !== 3'(k) || commit_reg !== 5'(k + 1) ||
          commit_data !== vals[k]) begin
        n_fail++;
        $display("FAIL order_commit%0d got v%b we%b f%b i%0d r%0d d%h want 1 1 0 %0d %0d %h",
                 k, commit_valid, commit_we, flush, commit_index,
                 commit_reg, commit_data, k, k + 1, vals[k]);
      end
      tick();
    end
    n_chk++;
    if (commit_valid !== 1'b0 || CDB_data_valid !== 8'h00) begin
      n_fail++;
      $display("FAIL order_drain got %b/%b want 0/0",
               commit_valid, CDB_data_valid);
    end
  endtask

  task automatic test_full_wrap();
    logic ok;
    do_reset();
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      alloc_req = 1'b1;
      alloc_reg = 5'(k + 8);
      #1;
      if (alloc_ack !== 1'b1) ok = 1'b0;
      tick();
    end
    n_chk++;
    if (ok !== 1'b1 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_fill got ok%b full%b want 1/1", ok, full);
    end
    alloc_reg = 5'd20;
    #1;
    n_chk++;
    if (alloc_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL full_reject got %b want 0", alloc_ack);
    end
    fu(0, 3'd0, 16'h0ABC);
    tick();
    valid_bus = '0;
    #1;
    n_chk++;
    if (alloc_ack !== 1'b0 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_retire_rej got %b/%b want 0/1",
               alloc_ack, full);
    end
    tick();
    n_chk++;
    if (commit_valid !== 1'b1 || commit_index !== 3'd0 ||
        full !== 1'b0 || alloc_index !== 3'd0 ||
        alloc_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL full_wrap got v%b i%0d full%b ai%0d ack%b want 1 0 0 0 1",
               commit_valid, commit_index, full, alloc_index, alloc_ack);
    end
    tick();
    alloc_req = 1'b0;
    n_chk++;
    if (full !== 1'b1 || alloc_index !== 3'd1) begin
      n_fail++;
      $display("FAIL full_refill got %b/%0d want 1/1",
               full, alloc_index);
    end
  endtask

  task automatic test_flush();
    do_reset();
    alloc(5'd0, 1'b1);
    alloc(5'd4, 1'b0);
    alloc(5'd5, 1'b0);
    fu(1, 3'd1, 16'h0011);
    tick();
    clr_in();
    fu(3, 3'd0, 16'h0001);
    tick();
    clr_in();
    fu(0, 3'd2, 16'h0022);
    alloc_req = 1'b1;
    #1;
    n_chk++;
    if (alloc_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ack got %b want 0", alloc_ack);
    end
    tick();
    clr_in();
    n_chk++;
    if ({commit_valid, commit_we, flush} !== 3'b101 ||
        commit_index !== 3'd0 || reset_bus !== 4'hF) begin
      n_fail++;
      $display("FAIL flush_strobe got %b i%0d rb%b want 101 0 1111",
               {commit_valid, commit_we, flush}, commit_index, reset_bus);
    end
    n_chk++;
    if (CDB_data_valid !== 8'h00 || alloc_index !== 3'd0 ||
        full !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear got %b/%0d/%b want 0/0/0",
               CDB_data_valid, alloc_index, full);
    end
    tick();
    n_chk++;
    if ({commit_valid, flush} !== 2'b00 || reset_bus !== 4'h0) begin
      n_fail++;
      $display("FAIL flush_end got %b/%b want 00/0000",
               {commit_valid, flush}, reset_bus);
    end
    alloc_req = 1'b1;
    alloc_reg = 5'd9;
    #1;
    n_chk++;
    if (alloc_ack !== 1'b1 || alloc_index !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_realloc got %b/%0d want 1/0",
               alloc_ack, alloc_index);
    end
    tick();
    alloc_req = 1'b0;
  endtask

  task automatic test_same_entry();
    do_reset();
    for (int k = 0; k < 4; k++) alloc(5'(k), 1'b0);
    fu(0, 3'd3, 16'hAAAA);
    fu(1, 3'd3, 16'hBBBB);
    tick();
    clr_in();
    n_chk++;
    if (CDB_data_valid !== 8'h08 || CDB_data_data[63:48] !== 16'hAAAA ||
        reset_bus !== 4'b0011) begin
      n_fail++;
      $display("FAIL same_entry got %b/%h/%b want 00001000/aaaa/0011",
               CDB_data_valid, CDB_data_data[63:48], reset_bus);
    end
    for (int k = 4; k < 8; k++) alloc(5'(k), 1'b0);
    fu(3, NULL, 16'h7777);
    tick();
    clr_in();
    n_chk++;
    if (CDB_data_valid !== 8'h08 || reset_bus !== 4'b1000) begin
      n_fail++;
      $display("FAIL null_tag got %b/%b want 00001000/1000",
               CDB_data_valid, reset_bus);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int k = 0; k < 4; k++) alloc(5'(k + 1), 1'b0);
    fu(0, 3'd1, 16'h1234);
    tick();
    clr_in();
    reset = 1'b1;
    fu(1, 3'd0, 16'h4321);
    alloc_req = 1'b1;
    #1;
    n_chk++;
    if (alloc_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ack got %b want 0", alloc_ack);
    end
    tick();
    n_chk++;
    if ({commit_valid, commit_we, commit_reg, commit_data,
         commit_index, flush, full, alloc_index} !== '0 ||
        {CDB_data_valid, CDB_data_data} !== '0 ||
        reset_bus !== 4'hF) begin
      n_fail++;
      $display("FAIL rst_inflight got cv%b f%b full%b ai%0d cdbv%b rb%b want zeros rb 1111",
               commit_valid, flush, full, alloc_index,
               CDB_data_valid, reset_bus);
    end
    reset = 1'b0;
    clr_in();
    tick();
    n_chk++;
    if (CDB_data_valid !== 8'h00 || reset_bus !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_after got %b/%b want 0/0",
               CDB_data_valid, reset_bus);
    end
  endtask

  task automatic test_random();
    mrec_t mq[$];
    mrec_t nr;
    logic [2:0] tl;
    logic [2:0] ix;
    logic [FU_NUM-1:0] e_rb;
    logic [2:0] e_ctl;
    logic [23:0] e_fld;
    logic [7:0] ev;
    logic [127:0] ed;
    logic [127:0] em;
    logic ret, fl, eack;
    for (int ep = 0; ep < 6; ep++) begin
      reset = 1'b1;
      clr_in();
      tick();
      reset = 1'b0;
      mq.delete();
      tl = '0;
      e_rb = '1;
      e_ctl = '0;
      e_fld = '0;
      for (int c = 0; c < 80; c++) begin
        ev = '0;
        ed = '0;
        em = '0;
        foreach (mq[k]) begin
          if (mq[k].done) begin
            ev[mq[k].idx] = 1'b1;
            ed[mq[k].idx*16 +: 16] = mq[k].val;
            em[mq[k].idx*16 +: 16] = 16'hFFFF;
          end
        end
        n_chk++;
        if ({commit_valid, commit_we, flush} !== e_ctl) begin
          n_fail++;
          $display("FAIL rnd_ctl ep%0d c%0d got %b want %b",
                   ep, c, {commit_valid, commit_we, flush}, e_ctl);
        end
        if (e_ctl[2]) begin
          n_chk++;
          if ({commit_reg, commit_data, commit_index} !== e_fld) begin
            n_fail++;
            $display("FAIL rnd_commit ep%0d c%0d got %h want %h",
                     ep, c, {commit_reg, commit_data, commit_index}, e_fld);
          end
        end
        n_chk++;
        if (reset_bus !== e_rb) begin
          n_fail++;
          $display("FAIL rnd_rbus ep%0d c%0d got %b want %b",
                   ep, c, reset_bus, e_rb);
        end
        n_chk++;
        if (CDB_data_valid !== ev || (CDB_data_data & em) !== ed) begin
          n_fail++;
          $display("FAIL rnd_cdb ep%0d c%0d got %b/%h want %b/%h",
                   ep, c, CDB_data_valid, CDB_data_data & em, ev, ed);
        end
        n_chk++;
        if (full !== (mq.size() == 8) || alloc_index !== tl) begin
          n_fail++;
          $display("FAIL rnd_ptr ep%0d c%0d got %b/%0d want %b/%0d",
                   ep, c, full, alloc_index, mq.size() == 8, tl);
        end
        alloc_req = ($urandom_range(0, 2) != 0);
        alloc_reg = 5'($urandom);
        alloc_is_branch = ($urandom_range(0, 5) == 0);
        for (int f = 0; f < FU_NUM; f++) begin
          valid_bus[f] = ($urandom_range(0, 2) == 0);
          if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            ix = mq[$urandom_range(0, mq.size() - 1)].idx;
          else
            ix = 3'($urandom);
          RB_index_bus[f*3 +: 3] = ix;
          data_bus[f*16 +: 16] = 16'($urandom);
        end
        #1;
        ret = (mq.size() > 0) && mq[0].done;
        fl = ret && mq[0].br && mq[0].val[0];
        eack = alloc_req && (mq.size() < 8) && !fl;
        n_chk++;
        if (alloc_ack !== eack) begin
          n_fail++;
          $display("FAIL rnd_ack ep%0d c%0d got %b want %b",
                   ep, c, alloc_ack, eack);
        end
        e_ctl = ret ? {1'b1, !mq[0].br, fl} : 3'b000;
        e_fld = ret ? {mq[0].rd, mq[0].val, mq[0].idx} : 24'h0;
        e_rb = fl ? 4'hF : valid_bus;
        if (fl) begin
          mq.delete();
          tl = '0;
        end else begin
          if (ret) void'(mq.pop_front());
          for (int f = 0; f < FU_NUM; f++) begin
            ix = RB_index_bus[f*3 +: 3];
            if (valid_bus[f] && ix != NULL) begin
              foreach (mq[k]) begin
                if (mq[k].idx == ix && !mq[k].done) begin
                  mq[k].done = 1'b1;
                  mq[k].val = data_bus[f*16 +: 16];
                end
              end
            end
          end
          if (eack) begin
            nr.idx = tl;
            nr.rd = alloc_reg;
            nr.br = alloc_is_branch;
            nr.done = 1'b0;
            nr.val = '0;
            mq.push_back(nr);
            tl = tl + 3'd1;
          end
        end
        tick();
      end
    end
    clr_in();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    clr_in();
    test_reset();
    test_writeback();
    test_in_order();
    test_full_wrap();
    test_flush();
    test_same_entry();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
